// File: rtl/offchip_mem_arbiter_pkg.sv
// Shared types and line geometry for the off-chip memory arbiter.
// Requester identifiers and FSM state encodings live here.
package offchip_mem_arbiter_pkg;

  localparam int unsigned CFG_LINE_BYTES = 16;
  localparam int unsigned CFG_ADDR_W     = 32;
  localparam int unsigned LINE_BITS      = CFG_LINE_BYTES * 8;
  localparam int unsigned OFFSET_BITS    = $clog2(CFG_LINE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

endpackage

// File: rtl/offchip_mem_arbiter_if.sv
// Off-chip memory port bundle: the arbiter is master, the memory is slave.
interface offchip_mem_arbiter_if
  import offchip_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = CFG_ADDR_W,
  parameter int unsigned DATA_W = LINE_BITS
);
  logic              offchip_mem_read_en;
  logic              offchip_mem_write_en;
  logic [ADDR_W-1:0] offchip_mem_addr;
  logic [DATA_W-1:0] offchip_mem_wdata;
  logic [DATA_W-1:0] offchip_mem_data;
  logic              offchip_mem_ready;

  modport master (
    output offchip_mem_read_en, offchip_mem_write_en, offchip_mem_addr, offchip_mem_wdata,
    input  offchip_mem_data, offchip_mem_ready
  );

  modport slave (
    input  offchip_mem_read_en, offchip_mem_write_en, offchip_mem_addr, offchip_mem_wdata,
    output offchip_mem_data, offchip_mem_ready
  );
endinterface

// File: rtl/offchip_mem_arbiter_rr2.sv
// Two-way round-robin pick between I-cache and D-cache requests.
module mem_arb_rr2
  import offchip_mem_arbiter_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_e last_grant,
  output logic    grant_valid,
  output req_id_e grant_id
);
  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = REQ_I;
    if (i_req && d_req) begin
      grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req) begin
      grant_id = REQ_D;
    end
  end
endmodule

// File: rtl/offchip_mem_arbiter.sv
// Owns the single off-chip memory port: arbitrates I/D cache line requests,
// sequences issue/wait/capture/recover and returns line + done (err on timeout).
module offchip_mem_arbiter
  import offchip_mem_arbiter_pkg::*;
#(
  parameter int unsigned LINE_BYTES = CFG_LINE_BYTES,
  parameter int unsigned ADDR_W     = CFG_ADDR_W,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_W-1:0]       i_addr,
  output logic                    i_done,
  output logic [LINE_BYTES*8-1:0] i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_W-1:0]       d_addr,
  input  logic [LINE_BYTES*8-1:0] d_wdata,
  output logic                    d_done,
  output logic [LINE_BYTES*8-1:0] d_rdata,
  offchip_mem_arbiter_if.master   mem,
  output logic                    err
);
  localparam int unsigned LB       = LINE_BYTES * 8;
  localparam int unsigned OFF_BITS = $clog2(LINE_BYTES);
  localparam int unsigned CNT_W    = 16;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  req_id_e           last_grant_q, last_grant_d;
  req_id_e           owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              read_en_q, read_en_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LB-1:0]     wdata_q, wdata_d;
  logic [LB-1:0]     i_rdata_q, i_rdata_d;
  logic [LB-1:0]     d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;

  logic    grant_valid;
  req_id_e grant_id;
  logic    timed_out;

  mem_arb_rr2 u_rr2 (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign timed_out = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_I;
      owner_q      <= REQ_I;
      cnt_q        <= '0;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      read_en_q    <= read_en_d;
      write_en_q   <= write_en_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (grant_valid) state_d = ST_BUSY;
      ST_BUSY:    if (mem.offchip_mem_ready || timed_out) state_d = ST_RECOVER;
      // Leaving only once ready is low keeps a stale ready from completing the next issue.
      ST_RECOVER: if (!mem.offchip_mem_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    read_en_d    = read_en_q;
    write_en_d   = write_en_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_id;
          owner_d      = grant_id;
          cnt_d        = '0;
          if (grant_id == REQ_D) begin
            addr_d = d_addr & ALIGN_MASK;
            if (d_we) begin
              wdata_d    = d_wdata;
              write_en_d = 1'b1;
            end else begin
              read_en_d = 1'b1;
            end
          end else begin
            addr_d    = i_addr & ALIGN_MASK;
            read_en_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (mem.offchip_mem_ready || timed_out) begin
          read_en_d  = 1'b0;
          write_en_d = 1'b0;
          err_d      = !mem.offchip_mem_ready;
          if (owner_q == REQ_D) d_done_d = 1'b1;
          else                  i_done_d = 1'b1;
          if (mem.offchip_mem_ready && read_en_q) begin
            if (owner_q == REQ_D) d_rdata_d = mem.offchip_mem_data;
            else                  i_rdata_d = mem.offchip_mem_data;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        read_en_d  = 1'b0;
        write_en_d = 1'b0;
      end
    endcase
  end

  assign mem.offchip_mem_read_en  = read_en_q;
  assign mem.offchip_mem_write_en = write_en_q;
  assign mem.offchip_mem_addr     = addr_q;
  assign mem.offchip_mem_wdata    = wdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;
endmodule

// File: tb/tb_offchip_mem_arbiter.sv
// Directed bench for offchip_mem_arbiter with hand-computed expectations (TIMEOUT=8).
module tb_offchip_mem_arbiter;
  import offchip_mem_arbiter_pkg::*;

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D3 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] D4 = 128'h0F0F0F0F_F0F0F0F0_5A5A5A5A_A5A5A5A5;
  localparam logic [127:0] D5 = 128'h00000001_00000002_00000003_00000004;
  localparam logic [127:0] D6 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
  localparam logic [127:0] D7 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_req = 1'b0;
  logic [31:0]  i_addr = '0;
  logic         i_done;
  logic [127:0] i_rdata;
  logic         d_req = 1'b0;
  logic         d_we = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [127:0] d_wdata = '0;
  logic         d_done;
  logic [127:0] d_rdata;
  logic         err;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned viol = 0;

  offchip_mem_arbiter_if #(.ADDR_W(32), .DATA_W(128)) mem_bus ();

  offchip_mem_arbiter #(.LINE_BYTES(16), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_done  (i_done),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_done  (d_done),
    .d_rdata (d_rdata),
    .mem     (mem_bus),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_bus.offchip_mem_read_en && mem_bus.offchip_mem_write_en) viol++;
    if (i_done && d_done) viol++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic idle_quiet();
    mem_bus.offchip_mem_ready = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    mem_bus.offchip_mem_ready = 1'b0;
    mem_bus.offchip_mem_data  = '0;

    // reset state
    do_reset();
    chk("rst_read_en", mem_bus.offchip_mem_read_en, 0);
    chk("rst_write_en", mem_bus.offchip_mem_write_en, 0);
    chk("rst_addr", mem_bus.offchip_mem_addr, 0);
    chk("rst_wdata", mem_bus.offchip_mem_wdata, 0);
    chk("rst_rdata", {i_rdata ^ d_rdata}, 0);
    chk("rst_done_err", {i_done, d_done, err}, 0);

    // I-cache read, ready held two cycles
    i_req = 1'b1; i_addr = 32'h0000_0013;
    step();
    chk("t1_addr", mem_bus.offchip_mem_addr, 32'h10);
    chk("t1_read_en", mem_bus.offchip_mem_read_en, 1);
    mem_bus.offchip_mem_ready = 1'b1; mem_bus.offchip_mem_data = D1;
    step();
    chk("t1_i_done", i_done, 1);
    chk("t1_i_rdata", i_rdata, D1);
    chk("t1_read_en_low", mem_bus.offchip_mem_read_en, 0);
    chk("t1_err", err, 0);
    i_req = 1'b0;
    step();
    chk("t1_done_once", i_done, 0);
    chk("t1_no_reissue", mem_bus.offchip_mem_read_en, 0);
    mem_bus.offchip_mem_ready = 1'b0;
    step();
    step();
    chk("t1_idle_read_en", mem_bus.offchip_mem_read_en, 0);

    // D writeback
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = {16{8'hA5}};
    step();
    chk("t2_write_en", mem_bus.offchip_mem_write_en, 1);
    chk("t2_read_en", mem_bus.offchip_mem_read_en, 0);
    chk("t2_addr", mem_bus.offchip_mem_addr, 32'h40);
    chk("t2_wdata", mem_bus.offchip_mem_wdata, {16{8'hA5}});
    step();
    chk("t2_write_hold", {mem_bus.offchip_mem_write_en, mem_bus.offchip_mem_read_en, d_done}, 3'b100);
    mem_bus.offchip_mem_ready = 1'b1; mem_bus.offchip_mem_data = D2;
    step();
    chk("t2_d_done", d_done, 1);
    chk("t2_write_low", mem_bus.offchip_mem_write_en, 0);
    chk("t2_d_rdata", d_rdata, 0);
    chk("t2_i_rdata_kept", i_rdata, D1);
    idle_quiet(); d_we = 1'b0;
    step();
    step();

    // tie from reset: D, then I, then D again
    do_reset();
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h80;
    step();
    chk("t3_first_d_addr", mem_bus.offchip_mem_addr, 32'h80);
    step();
    step();
    mem_bus.offchip_mem_ready = 1'b1; mem_bus.offchip_mem_data = D2;
    step();
    chk("t3_d_done", {d_done, i_done}, 2'b10);
    chk("t3_d_rdata", d_rdata, D2);
    d_req = 1'b0; mem_bus.offchip_mem_ready = 1'b0;
    step();
    step();
    chk("t3_then_i_addr", mem_bus.offchip_mem_addr, 32'h100);
    chk("t3_then_i_read", mem_bus.offchip_mem_read_en, 1);
    step();
    mem_bus.offchip_mem_ready = 1'b1; mem_bus.offchip_mem_data = D3;
    step();
    chk("t3_i_done", {d_done, i_done}, 2'b01);
    chk("t3_i_rdata", i_rdata, D3);
    chk("t3_d_rdata_kept", d_rdata, D2);
    i_req = 1'b0; mem_bus.offchip_mem_ready = 1'b0;
    step();
    i_req = 1'b1; d_req = 1'b1;
    step();
    chk("t3_second_tie_d", mem_bus.offchip_mem_addr, 32'h80);
    mem_bus.offchip_mem_ready = 1'b1; mem_bus.offchip_mem_data = D4;
    step();
    chk("t3_d_done2", {d_done, i_done}, 2'b10);
    chk("t3_d_rdata2", d_rdata, D4);
    d_req = 1'b0; mem_bus.offchip_mem_ready = 1'b0;
    step();
    step();
    chk("t3_i_after_tie2", mem_bus.offchip_mem_addr, 32'h100);
    mem_bus.offchip_mem_ready = 1'b1; mem_bus.offchip_mem_data = D1;
    step();
    chk("t3_i_done2", i_done, 1);
    idle_quiet();
    step();

    // timeout on a D read, ready never asserted
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    step();
    chk("t4_read_en", mem_bus.offchip_mem_read_en, 1);
    for (int k = 1; k < 8; k++) step();
    chk("t4_no_done_yet", {d_done, err, mem_bus.offchip_mem_read_en}, 3'b001);
    step();
    chk("t4_done_err", {d_done, err}, 2'b11);
    chk("t4_strobe_low", mem_bus.offchip_mem_read_en, 0);
    chk("t4_d_rdata_kept", d_rdata, D4);
    d_req = 1'b0;
    step();
    chk("t4_pulse_end", {d_done, err}, 2'b00);
    step();

    // reset in the middle of BUSY
    i_req = 1'b1; i_addr = 32'h300;
    step();
    chk("t5_busy_read_en", mem_bus.offchip_mem_read_en, 1);
    rst = 1'b0;
    step();
    chk("t5_rst_strobes", {mem_bus.offchip_mem_read_en, mem_bus.offchip_mem_write_en}, 0);
    chk("t5_rst_done_err", {i_done, d_done, err}, 0);
    chk("t5_rst_i_rdata", i_rdata, 0);
    chk("t5_rst_d_rdata", d_rdata, 0);
    rst = 1'b1;
    step();
    chk("t5_fresh_addr", mem_bus.offchip_mem_addr, 32'h300);
    chk("t5_fresh_read", mem_bus.offchip_mem_read_en, 1);
    mem_bus.offchip_mem_ready = 1'b1; mem_bus.offchip_mem_data = D5;
    step();
    chk("t5_fresh_done", {i_done, i_rdata}, {1'b1, D5});
    idle_quiet();
    step();

    // stuck ready holds RECOVER with a request pending
    i_req = 1'b1; i_addr = 32'h400;
    step();
    mem_bus.offchip_mem_ready = 1'b1; mem_bus.offchip_mem_data = D6;
    step();
    chk("t6_i_done", {i_done, i_rdata}, {1'b1, D6});
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_held", {mem_bus.offchip_mem_read_en, mem_bus.offchip_mem_write_en, d_done}, 0);
    end
    mem_bus.offchip_mem_ready = 1'b0;
    step();
    chk("t6_leave_recover", mem_bus.offchip_mem_read_en, 0);
    step();
    chk("t6_issue", {mem_bus.offchip_mem_read_en, mem_bus.offchip_mem_addr}, {1'b1, 32'h500});
    mem_bus.offchip_mem_ready = 1'b1; mem_bus.offchip_mem_data = D7;
    step();
    chk("t6_d_done", {d_done, d_rdata}, {1'b1, D7});
    idle_quiet();
    step();
    step();

    chk("invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/offchip_mem_arbiter.md
Name: offchip_mem_arbiter

Overview:
- Sole owner of the CPU's single off-chip memory port (cache-line wide read/write, level `ready` handshake).
- Arbitrates between instruction-cache refill requests (read only) and data-cache refill/writeback requests (read or write).
- Sequences each transaction (issue, wait, capture, release, recover) and returns the line plus a one-cycle `done` to the winning requester.
- Sits between the I/D caches inside cpu_pipeline and the top-level offchip_mem_* pins.

Parameters:
- LINE_BYTES, 16 (`CACHE_LINE_SIZE): bytes per cache line. Data buses are LINE_BYTES*8 bits.
- ADDR_W, 32 (`MAX_BIT_POS+1): address width.
- TIMEOUT, 255: max cycles waiting for `ready` before aborting a transaction. Valid range is 1..65535.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- i_req  in  1  I-cache line read request; held until i_done
- i_addr  in  ADDR_W  I-cache line address
- i_done  out  1  one-cycle completion pulse to I-cache
- i_rdata  out  LINE_BYTES*8  returned line, valid when i_done=1
- d_req  in  1  D-cache request; held until d_done
- d_we  in  1  1 = writeback, 0 = refill
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_BYTES*8  writeback line
- d_done  out  1  one-cycle completion pulse to D-cache
- d_rdata  out  LINE_BYTES*8  returned line, valid when d_done=1
- offchip_mem_read_en  out  1  read strobe to memory
- offchip_mem_write_en  out  1  write strobe to memory
- offchip_mem_addr  out  ADDR_W  line-aligned address
- offchip_mem_wdata  out  LINE_BYTES*8  write data
- offchip_mem_data  in  LINE_BYTES*8  read data, valid while ready=1
- offchip_mem_ready  in  1  memory completion, level, may stay high several cycles
- err  out  1  one-cycle pulse, coincident with done, on timeout

Behaviour:
- Reset (rst=0 at a clock edge), taking effect regardless of state:
  - state=IDLE.
  - All strobes, done and err = 0.
  - addr, wdata, i_rdata, d_rdata = 0.
  - timeout counter = 0.
  - last_grant = I, so D wins the first tie.
- FSM states: IDLE, BUSY, RECOVER.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one requester asserting: it wins.
  - Both asserting: round-robin, the requester not in last_grant wins, then last_grant is updated.
  - On grant, at the same edge:
    - Register offchip_mem_addr = req_addr with the low log2(LINE_BYTES) bits forced to 0.
    - Register wdata = d_wdata for D writes; otherwise hold the previous value.
    - Assert read_en, or write_en for D with d_we=1.
    - Clear the counter and go to BUSY.
- Latency: req sampled at edge 0, strobe high from edge 0 (visible in cycle 1).
- BUSY: strobe, addr and wdata stay constant. Each cycle:
  - ready=1 sampled:
    - For reads, capture offchip_mem_data into the winner's rdata.
    - Pulse the winner's done for exactly one cycle.
    - Drop the strobe at the same edge and go to RECOVER.
  - Else counter = TIMEOUT-1: drop the strobe, pulse done and err, leave rdata unchanged, go to RECOVER.
  - Else increment the counter.
- RECOVER:
  - Strobes stay low; minimum 1 cycle.
  - Go to IDLE on the first edge where ready=0.
  - This guarantees a strobe low period between transactions, so no stale `ready` is ever accepted.
  - Because the done pulse ends before IDLE, the requester (which drops req on seeing done) is never double-served.
- read_en and write_en are never high simultaneously. At most one of i_done / d_done is high in any cycle.
- rdata outputs hold their last captured line until that requester's next successful read completes.
- ready=1 while in IDLE or RECOVER is ignored.
- The register file is untouched by this block; the caches own data placement.

Decomposition:
- Shared package/header:
  - state encodings IDLE/BUSY/RECOVER
  - requester IDs REQ_I=0, REQ_D=1
  - LINE_BITS = LINE_BYTES*8 and OFFSET_BITS = log2(LINE_BYTES), derived from the existing config.v macros
- One sub-module, mem_arb_rr2: a combinational 2-way round-robin pick from (i_req, d_req, last_grant) producing grant_valid and grant_id. The FSM, counter and datapath registers stay in offchip_mem_arbiter.

Test Plan:
- I-cache read: i_req=1, i_addr=0x0000_0013; memory returns ready=1 for 2 cycles with data 0x00112233_44556677_8899AABB_CCDDEEFF. Expect:
  - addr=0x10 and read_en=1 one cycle after req
  - i_done for exactly 1 cycle with i_rdata equal to that value
  - read_en low after completion
  - no second read_en rising edge while ready stays high
- D writeback: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xA5 repeated. Expect write_en=1, addr=0x40, wdata=0xA5.., read_en=0 throughout, d_done pulse, d_rdata unchanged (0).
- Tie twice: both req high from reset with ready after 3 cycles. Expect grant order D, then I. Next tie, order D again. No cycle has both done high.
- Timeout with TIMEOUT=8: d_req read, ready never asserted. Expect d_done=1 and err=1 together, 8 cycles after strobe rise. Strobe drops, d_rdata unchanged, FSM returns to IDLE.
- Reset mid-BUSY: rst=0 for one edge while read_en=1. Expect next cycle: all strobes, done and err = 0, rdata = 0; a fresh i_req then completes normally.
- Stuck ready: ready forced high across completion. Expect FSM held in RECOVER with no new strobe, despite pending req, until ready=0; then issue on the next edge.
